// File: rtl/dadda_prod_accum.sv
// Accumulates unsigned Dadda multiplier products into one sum per group and hands it off on a valid/ready port.
// Optional macro DADDA_ACC_SATURATE_EN: clamp the sum to all ones on overflow instead of wrapping.
//
// state | meaning
// IDLE  | waiting for the first product of a group; the previous result is still visible
// ACCUM | adding products until prod_last or LEN products have arrived
// HOLD  | sum complete; held until the consumer takes it
module dadda_prod_accum #(
    parameter int WIDTH     = 16,
    parameter int LEN       = 8,
    parameter int ACC_WIDTH = 35
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prod_valid,
    output logic                       prod_ready,
    input  logic [2*WIDTH-1:0]         prod_in,
    input  logic                       prod_last,
    output logic                       acc_valid,
    input  logic                       acc_ready,
    output logic [ACC_WIDTH-1:0]       acc_out,
    output logic [$clog2(LEN+1)-1:0]   acc_cnt,
    output logic                       acc_ovf
);

    localparam int CNT_W = $clog2(LEN+1);
    localparam int SUM_W = ACC_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state;
    logic [SUM_W-1:0]     sum_ext;
    logic [ACC_WIDTH-1:0] sum_acc;
    logic [CNT_W-1:0]     cnt_next;

    // Handshake flags decode only the state register, so neither depends on the opposite-side inputs.
    assign prod_ready = (state != HOLD);
    assign acc_valid  = (state == HOLD);

    assign sum_ext  = {1'b0, acc_out} + SUM_W'(prod_in);
    assign cnt_next = acc_cnt + CNT_W'(1);

`ifdef DADDA_ACC_SATURATE_EN
    // Once the group has overflowed, the sum stays pinned at all ones.
    assign sum_acc = (sum_ext[ACC_WIDTH] || acc_ovf) ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
    assign sum_acc = sum_ext[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc_out <= '0;
            acc_cnt <= '0;
            acc_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (prod_valid) begin
                        acc_out <= ACC_WIDTH'(prod_in);
                        acc_cnt <= CNT_W'(1);
                        acc_ovf <= 1'b0;
                        if (prod_last || (LEN == 1))
                            state <= HOLD;
                        else
                            state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc_out <= sum_acc;
                        acc_cnt <= cnt_next;
                        if (sum_ext[ACC_WIDTH])
                            acc_ovf <= 1'b1;
                        if (prod_last || (cnt_next == CNT_W'(LEN)))
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (acc_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dadda_prod_accum.sv
// Directed bench for dadda_prod_accum: default build plus narrow-accumulator and LEN=1 instances.
module tb_dadda_prod_accum;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Default instance: WIDTH=16, LEN=8, ACC_WIDTH=35
    logic        pv = 1'b0, pl = 1'b0, ar = 1'b0;
    logic [31:0] pin = '0;
    logic        pr, av, aov;
    logic [34:0] ao;
    logic [3:0]  ac;

    // Narrow accumulators sharing one stimulus: LEN=2 and LEN=3, ACC_WIDTH=33
    logic        pv2 = 1'b0, pl2 = 1'b0, ar2 = 1'b0;
    logic [31:0] pin2 = '0;
    logic        pr_w, av_w, aov_w, pr_s, av_s, aov_s;
    logic [32:0] ao_w, ao_s;
    logic [1:0]  ac_w, ac_s;

    // LEN=1 instance
    logic        pv1 = 1'b0, pl1 = 1'b0, ar1 = 1'b0;
    logic [31:0] pin1 = '0;
    logic        pr_1, av_1, aov_1;
    logic [34:0] ao_1;
    logic [0:0]  ac_1;

`ifdef DADDA_ACC_SATURATE_EN
    localparam logic [32:0] EXP_S = 33'h1FFFFFFFF;
`else
    localparam logic [32:0] EXP_S = 33'h000000000;
`endif

    dadda_prod_accum dut (
        .clk(clk), .rst(rst), .prod_valid(pv), .prod_ready(pr), .prod_in(pin),
        .prod_last(pl), .acc_valid(av), .acc_ready(ar), .acc_out(ao),
        .acc_cnt(ac), .acc_ovf(aov)
    );

    dadda_prod_accum #(.WIDTH(16), .LEN(2), .ACC_WIDTH(33)) dut_w (
        .clk(clk), .rst(rst), .prod_valid(pv2), .prod_ready(pr_w), .prod_in(pin2),
        .prod_last(pl2), .acc_valid(av_w), .acc_ready(ar2), .acc_out(ao_w),
        .acc_cnt(ac_w), .acc_ovf(aov_w)
    );

    dadda_prod_accum #(.WIDTH(16), .LEN(3), .ACC_WIDTH(33)) dut_s (
        .clk(clk), .rst(rst), .prod_valid(pv2), .prod_ready(pr_s), .prod_in(pin2),
        .prod_last(pl2), .acc_valid(av_s), .acc_ready(ar2), .acc_out(ao_s),
        .acc_cnt(ac_s), .acc_ovf(aov_s)
    );

    dadda_prod_accum #(.WIDTH(16), .LEN(1), .ACC_WIDTH(35)) dut_1 (
        .clk(clk), .rst(rst), .prod_valid(pv1), .prod_ready(pr_1), .prod_in(pin1),
        .prod_last(pl1), .acc_valid(av_1), .acc_ready(ar1), .acc_out(ao_1),
        .acc_cnt(ac_1), .acc_ovf(aov_1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        pv  = 1'b1;
        pin = d;
        pl  = last;
        step();
        pv = 1'b0;
        pl = 1'b0;
    endtask

    task automatic release_result();
        ar = 1'b1;
        step();
        ar = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 64'(pr), 64'd1);
        chk("rst_valid", 64'(av), 64'd0);
        chk("rst_out",   64'(ao), 64'd0);
        chk("rst_cnt",   64'(ac), 64'd0);
        chk("rst_ovf",   64'(aov), 64'd0);

        // eight products of 8, no prod_last
        for (int i = 0; i < 7; i++) send(32'd8, 1'b0);
        chk("g8_valid_early", 64'(av), 64'd0);
        send(32'd8, 1'b0);
        chk("g8_valid", 64'(av), 64'd1);
        chk("g8_out",   64'(ao), 64'd64);
        chk("g8_cnt",   64'(ac), 64'd8);
        chk("g8_ovf",   64'(aov), 64'd0);
        chk("g8_ready", 64'(pr), 64'd0);
        step();
        step();
        chk("g8_hold_ready", 64'(pr), 64'd0);
        chk("g8_hold_valid", 64'(av), 64'd1);
        release_result();
        chk("g8_rel_ready", 64'(pr), 64'd1);
        chk("g8_rel_valid", 64'(av), 64'd0);
        chk("g8_rel_out",   64'(ao), 64'd64);
        chk("g8_rel_cnt",   64'(ac), 64'd8);

        // early close on the third product
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        send(32'd30, 1'b1);
        chk("g3_valid", 64'(av), 64'd1);
        chk("g3_out",   64'(ao), 64'd60);
        chk("g3_cnt",   64'(ac), 64'd3);
        release_result();
        chk("g3_rel_ready", 64'(pr), 64'd1);

        // prod_last without prod_valid does nothing
        pl = 1'b1;
        step();
        pl = 1'b0;
        chk("lastnv_valid", 64'(av), 64'd0);
        chk("lastnv_out",   64'(ao), 64'd60);

        // backpressure: producer keeps offering 7 while the result is held
        send(32'd5, 1'b1);
        pv  = 1'b1;
        pin = 32'd7;
        pl  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out",   64'(ao), 64'd5);
            chk("bp_cnt",   64'(ac), 64'd1);
            chk("bp_ready", 64'(pr), 64'd0);
        end
        release_result();
        chk("bp_rel_valid", 64'(av), 64'd0);
        chk("bp_rel_ready", 64'(pr), 64'd1);
        step();
        pv = 1'b0;
        pl = 1'b0;
        chk("bp_new_valid", 64'(av), 64'd1);
        chk("bp_new_out",   64'(ao), 64'd7);
        chk("bp_new_cnt",   64'(ac), 64'd1);
        release_result();

        // prod_last coinciding with the LEN-th product closes once
        for (int i = 0; i < 7; i++) send(32'd2, 1'b0);
        send(32'd2, 1'b1);
        chk("l8_out", 64'(ao), 64'd16);
        chk("l8_cnt", 64'(ac), 64'd8);
        release_result();
        chk("l8_rel_ready", 64'(pr), 64'd1);
        chk("l8_rel_valid", 64'(av), 64'd0);

        // reset midway through a group
        for (int i = 0; i < 4; i++) send(32'd3, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_out",   64'(ao), 64'd0);
        chk("mr_cnt",   64'(ac), 64'd0);
        chk("mr_ready", 64'(pr), 64'd1);
        chk("mr_valid", 64'(av), 64'd0);
        for (int i = 0; i < 8; i++) send(32'd1, 1'b0);
        chk("mr_g_out",   64'(ao), 64'd8);
        chk("mr_g_cnt",   64'(ac), 64'd8);
        chk("mr_g_valid", 64'(av), 64'd1);
        release_result();

        // 33-bit accumulators: 0xFFFFFFFF + 0xFFFFFFFF (+ 2 for LEN=3)
        pv2  = 1'b1;
        pin2 = 32'hFFFFFFFF;
        step();
        step();
        pin2 = 32'd2;
        chk("w_out",   64'(ao_w), 64'h1FFFFFFFE);
        chk("w_ovf",   64'(aov_w), 64'd0);
        chk("w_valid", 64'(av_w), 64'd1);
        chk("w_cnt",   64'(ac_w), 64'd2);
        chk("s2_valid", 64'(av_s), 64'd0);
        chk("s2_out",   64'(ao_s), 64'h1FFFFFFFE);
        step();
        pv2 = 1'b0;
        chk("s_out",   64'(ao_s), 64'(EXP_S));
        chk("s_ovf",   64'(aov_s), 64'd1);
        chk("s_valid", 64'(av_s), 64'd1);
        chk("s_cnt",   64'(ac_s), 64'd3);
        chk("w_held_out", 64'(ao_w), 64'h1FFFFFFFE);

        // LEN=1 closes on the first product
        pv1  = 1'b1;
        pin1 = 32'h12345678;
        step();
        pv1 = 1'b0;
        chk("one_valid", 64'(av_1), 64'd1);
        chk("one_out",   64'(ao_1), 64'h12345678);
        chk("one_cnt",   64'(ac_1), 64'd1);
        chk("one_ready", 64'(pr_1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dadda_prod_accum.md
Name: dadda_prod_accum

Overview:
- Downstream consumer of the 16-bit Dadda multiplier stage.
- Accepts the full product {overflow, out} (2*WIDTH bits) through a valid/ready handshake and accumulates up to LEN products into one unsigned sum, i.e. a dot-product reduction.
- Presents the finished sum on an output valid/ready handshake with an accumulator-overflow flag.
- Registers and sequences the combinational multiplier's results for the datapath behind it.

Parameters:
- WIDTH, 16, multiplier operand width; the product is 2*WIDTH bits.
- LEN, 8, maximum products per accumulation group; must be at least 1.
- ACC_WIDTH, 35, accumulator width; must be at least 2*WIDTH.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- prod_valid  input  1  product on prod_in is valid.
- prod_ready  output  1  block can accept a product this cycle.
- prod_in  input  2*WIDTH  unsigned product {overflow, out} from the multiplier.
- prod_last  input  1  qualifies prod_in as the final product of the group (early close).
- acc_valid  output  1  acc_out holds a completed sum.
- acc_ready  input  1  consumer accepts acc_out.
- acc_out  output  ACC_WIDTH  accumulated sum.
- acc_cnt  output  $clog2(LEN+1)  number of products in the current or held group.
- acc_ovf  output  1  sticky per group: a carry out of ACC_WIDTH occurred.

Behaviour:
- Reset values, applied on the next clk edge with rst=1 regardless of state:
  - state=IDLE, acc_out=0, acc_cnt=0, acc_ovf=0, acc_valid=0, prod_ready=1 (combinational from state; goes to 1 on the first edge after reset).
  - Reset mid-group discards the partial sum.
- A beat transfers when prod_valid && prod_ready. A result transfers when acc_valid && acc_ready.
- States:
  - IDLE: prod_ready=1, acc_valid=0. On a beat: acc_out<=zero-extended prod_in, acc_cnt<=1, acc_ovf<=0. Next state is HOLD if prod_last or LEN==1, otherwise ACCUM.
  - ACCUM: prod_ready=1. On a beat: acc_out<=acc_out+prod_in, computed at ACC_WIDTH+1 bits; acc_cnt<=acc_cnt+1. Next state is HOLD if prod_last or acc_cnt+1==LEN.
  - HOLD: prod_ready=0, acc_valid=1. acc_out, acc_cnt and acc_ovf are stable until the result transfers. On the result transfer go to IDLE; acc_cnt and acc_out retain their values until the next first beat overwrites them.
- Latency:
  - A sum is visible on acc_out the cycle after the final beat.
  - acc_valid asserts that same cycle.
  - Throughput: one product per cycle. One bubble cycle minimum per group, because no beat is accepted in HOLD.
- prod_last asserted on the LEN-th beat: single close, no double count.
- prod_last is ignored when prod_valid=0.
- Carry out of bit ACC_WIDTH-1 sets acc_ovf. acc_ovf stays set until the next group's first beat.
- prod_valid held while prod_ready=0: no effect. The producer must hold prod_in stable.
- No combinational path from prod_valid to prod_ready or from acc_ready to acc_valid.

Optional Feature:
- Macro: DADDA_ACC_SATURATE_EN.
- Defined: on a carry out, acc_out clamps to all ones and remains all ones for the rest of the group. acc_ovf is set.
- Undefined: acc_out wraps modulo 2^ACC_WIDTH. acc_ovf is still set.

Test Plan:
- Reset, then 8 beats of prod_in=8 (2*4), prod_last=0 → acc_valid rises the cycle after beat 8; acc_out=64, acc_cnt=8, acc_ovf=0, prod_ready=0 until acc_ready.
- 3 beats (10, 20, 30) with prod_last on the third → acc_out=60, acc_cnt=3; on acc_ready=1 return to IDLE, prod_ready=1 the next cycle.
- Hold acc_ready=0 for 5 cycles in HOLD while prod_valid=1 → no beat accepted; acc_out and acc_cnt stable; on release, a new group starts from the held prod_in.
- ACC_WIDTH=33, LEN=2, beats 0xFFFFFFFF and 0xFFFFFFFF → without the macro acc_out=0x1FFFFFFFE, acc_ovf=0. With LEN=3 and a third beat of 2: without the macro acc_out=0x000000000, acc_ovf=1; with DADDA_ACC_SATURATE_EN acc_out=0x1FFFFFFFF, acc_ovf=1.
- Assert rst after 4 of 8 beats → next cycle acc_out=0, acc_cnt=0, state IDLE; a following group of 8 beats of 1 yields acc_out=8.
- LEN=1, single beat 0x12345678 with prod_last=0 → HOLD immediately, acc_out=0x12345678, acc_cnt=1.
